// File: rtl/fpu_issue_ctrl_pkg.sv
// rtl/fpu_issue_ctrl_pkg.sv - shared types, state encoding and NaN constants for the fpu issue controller
package fpu_issue_ctrl_pkg;

  typedef logic [15:0] fp16_t;
  typedef logic [31:0] fp32_t;
  typedef logic [63:0] fp64_t;

  typedef logic [2:0] fpuOp_t;
  localparam fpuOp_t FPU_OP_ADD  = 3'd0;
  localparam fpuOp_t FPU_OP_SUB  = 3'd1;
  localparam fpuOp_t FPU_OP_MUL  = 3'd2;
  localparam fpuOp_t FPU_OP_DIV  = 3'd3;
  localparam fpuOp_t FPU_OP_SQRT = 3'd4;
  localparam fpuOp_t FPU_OP_FMA  = 3'd5;

  typedef logic [3:0] condCode_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } statusFlag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fpuIssueState_t;

  localparam fp16_t FP16_NAN = 16'h7E00;
  localparam fp32_t FP32_NAN = 32'h7FC0_0000;
  localparam fp64_t FP64_NAN = 64'h7FF8_0000_0000_0000;

  localparam statusFlag_t FLAGS_NV_ONLY = '{nv: 1'b1, default: 1'b0};

  // Quiet NaN for the operand width, zero-extended to 64 bits.
  function automatic logic [63:0] fp_nan(input int unsigned width);
    case (width)
      16:      return {48'd0, FP16_NAN};
      32:      return {32'd0, FP32_NAN};
      default: return FP64_NAN;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - command and response handshake bundle between the core and the issue controller
interface fpu_issue_ctrl_if
  import fpu_issue_ctrl_pkg::*;
#(
  parameter type FP_T  = fp16_t,
  parameter int  TAG_W = 4
) ();

  logic              req_valid;
  logic              req_ready;
  fpuOp_t            req_op;
  FP_T               req_a;
  FP_T               req_b;
  FP_T               req_c;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  FP_T               rsp_result;
  condCode_t         rsp_cc;
  statusFlag_t       rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_timeout;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cc, rsp_flags, rsp_tag, rsp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cc, rsp_flags, rsp_tag, rsp_timeout
  );

endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - issues one command at a time to the fpu, waits for done or timeout, returns a response
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter type FP_T    = fp16_t,
  parameter int  TAG_W   = 4,
  parameter int  TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  fpu_issue_ctrl_if.slave       core,

  output FP_T                   fpu_in1_o,
  output FP_T                   fpu_in2_o,
  output FP_T                   fpu_in3_o,
  output fpuOp_t                fpu_op_o,
  output logic                  fpu_start_o,
  input  FP_T                   fpu_out_i,
  input  logic                  fpu_done_i,
  input  condCode_t             fpu_cc_i,
  input  statusFlag_t           fpu_flags_i,

  input  logic                  flags_clr_i,
  output statusFlag_t           sticky_flags_o,
  output logic                  busy_o
);

  localparam int FP_W  = $bits(FP_T);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [FP_W-1:0]  NAN_C    = FP_W'(fp_nan(FP_W));

  fpuIssueState_t    state_q, state_d;
  fpuOp_t            op_q, op_d;
  FP_T               a_q, a_d;
  FP_T               b_q, b_d;
  FP_T               c_q, c_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  FP_T               res_q, res_d;
  condCode_t         cc_q, cc_d;
  statusFlag_t       flags_q, flags_d;
  logic              timeout_q, timeout_d;
  statusFlag_t       sticky_q, sticky_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      cc_q      <= '0;
      flags_q   <= '0;
      timeout_q <= 1'b0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      cc_q      <= cc_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    cc_d      = cc_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;
    sticky_d  = sticky_q;

    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          op_d    = core.req_op;
          a_d     = core.req_a;
          b_d     = core.req_b;
          c_d     = core.req_c;
          tag_d   = core.req_tag;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done seen on the last counted cycle still wins over the timeout.
        if (fpu_done_i) begin
          res_d     = fpu_out_i;
          cc_d      = fpu_cc_i;
          flags_d   = fpu_flags_i;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d     = NAN_C;
          cc_d      = '0;
          flags_d   = FLAGS_NV_ONLY;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (core.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flags_clr_i) begin
      sticky_d = '0;
    end else if (state_q == WAIT && state_d == RESP) begin
      sticky_d = sticky_q | flags_d;
    end
  end

  // Ready is masked by reset so every output reads zero while reset is held.
  assign core.req_ready   = rst_ni && (state_q == IDLE);
  assign core.rsp_valid   = (state_q == RESP);
  assign core.rsp_result  = res_q;
  assign core.rsp_cc      = cc_q;
  assign core.rsp_flags   = flags_q;
  assign core.rsp_tag     = tag_q;
  assign core.rsp_timeout = timeout_q;

  assign fpu_in1_o      = a_q;
  assign fpu_in2_o      = b_q;
  assign fpu_in3_o      = c_q;
  assign fpu_op_o       = op_q;
  assign fpu_start_o    = (state_q == ISSUE);
  assign sticky_flags_o = sticky_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - scoreboard bench: random commands, behavioural fpu, decoupled response monitor
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int          TO_C  = 8;
  localparam int          TAG_W = 4;
  localparam logic [15:0] NAN16 = 16'h7E00;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [3:0]  tag;
    int          lat;
    bit          stale;
  } cmd_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  cc;
    logic [4:0]  flags;
    logic [3:0]  tag;
    bit          to;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fpu_in1, fpu_in2, fpu_in3, fpu_out;
  logic [2:0]  fpu_op;
  logic        fpu_start, fpu_done;
  logic [3:0]  fpu_cc;
  statusFlag_t fpu_flags, sticky;
  logic        flags_clr, busy;

  cmd_t        fpu_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          force_hold = 0;
  logic [4:0]  sticky_m = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_issue_ctrl_if #(.FP_T(fp16_t), .TAG_W(TAG_W)) bus ();

  fpu_issue_ctrl #(.FP_T(fp16_t), .TAG_W(TAG_W), .TIMEOUT(TO_C)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core           (bus),
    .fpu_in1_o      (fpu_in1),
    .fpu_in2_o      (fpu_in2),
    .fpu_in3_o      (fpu_in3),
    .fpu_op_o       (fpu_op),
    .fpu_start_o    (fpu_start),
    .fpu_out_i      (fpu_out),
    .fpu_done_i     (fpu_done),
    .fpu_cc_i       (fpu_cc),
    .fpu_flags_i    (fpu_flags),
    .flags_clr_i    (flags_clr),
    .sticky_flags_o (sticky),
    .busy_o         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // What the stand-in fpu produces: {flags, cc, result}.
  function automatic logic [24:0] fpu_beh(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] c);
    logic [15:0] r;
    if (op == 3'd0 && a == 16'h3C00 && b == 16'h4000) return {5'b00000, 4'b0100, 16'h4200};
    if (op == 3'd3 && b[14:0] == 15'd0 && a[14:0] != 15'd0)
      return {5'b01000, 4'b0000, {a[15] ^ b[15], 15'h7C00}};
    r = (a ^ {b[7:0], b[15:8]}) + c + {13'd0, op};
    return {r[12:8], r[3:0], r};
  endfunction

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [3:0] tag, input int lat, input bit stale);
    cmd_t        cm;
    exp_t        e;
    logic [24:0] r;
    int          guard = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_c     = c;
    bus.req_tag   = tag;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL req_accept: req_ready never seen for tag %h", tag);
      bus.req_valid = 1'b0;
      return;
    end
    cm = '{op, a, b, c, tag, lat, stale};
    r  = fpu_beh(op, a, b, c);
    if (lat < TO_C) e = '{r[15:0], r[19:16], r[24:20], tag, 1'b0, cyc + 3 + lat};
    else            e = '{NAN16, 4'd0, 5'b10000, tag, 1'b1, cyc + 2 + TO_C};
    fpu_q.push_back(cm);
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d busy=%b", exp_q.size(), busy);
    end
  endtask

  task automatic clear_sticky();
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    sticky_m  = '0;
    chk("sticky_clr", sticky, sticky_m);
  endtask

  initial begin : fake_fpu
    cmd_t        cm;
    logic [24:0] r;
    fpu_done  = 1'b0;
    fpu_out   = '0;
    fpu_cc    = '0;
    fpu_flags = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && fpu_start === 1'b1) begin
        if (fpu_q.size() == 0) begin
          chk("spurious_start", 64'd1, 64'd0);
          continue;
        end
        cm = fpu_q.pop_front();
        chk("issue_operands", {fpu_op, fpu_in1, fpu_in2, fpu_in3}, {cm.op, cm.a, cm.b, cm.c});
        if (cm.stale) begin
          fpu_done  = 1'b1;
          fpu_out   = 16'($urandom);
          fpu_cc    = 4'($urandom);
          fpu_flags = 5'($urandom);
        end
        r = fpu_beh(cm.op, cm.a, cm.b, cm.c);
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1 || bus.rsp_valid === 1'b1) break;
          chk("wait_stable", {fpu_start, fpu_op, fpu_in1, fpu_in2, fpu_in3},
              {1'b0, cm.op, cm.a, cm.b, cm.c});
          if (k >= cm.lat) begin
            fpu_done  = 1'b1;
            fpu_out   = r[15:0];
            fpu_cc    = r[19:16];
            fpu_flags = r[24:20];
          end else begin
            fpu_done  = 1'b0;
            fpu_out   = 16'($urandom);
            fpu_cc    = 4'($urandom);
            fpu_flags = 5'($urandom);
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t cur;
    bit   in_rsp = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        in_rsp = 1'b0;
        continue;
      end
      chk("ready_iff_idle", bus.req_ready, !busy);
      if (bus.rsp_valid === 1'b1) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {60'd0, bus.rsp_tag}, 64'hDEAD);
          end else begin
            cur = exp_q.pop_front();
            chk("rsp_latency", cyc, cur.due);
            sticky_m = sticky_m | cur.flags;
          end
          in_rsp = 1'b1;
        end
        chk("rsp_fields", {bus.rsp_result, bus.rsp_cc, bus.rsp_flags, bus.rsp_tag, bus.rsp_timeout},
            {cur.res, cur.cc, cur.flags, cur.tag, cur.to});
        if (force_hold > 0) begin
          bus.rsp_ready = 1'b0;
          force_hold--;
        end else begin
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.rsp_ready) in_rsp = 1'b0;
      end else begin
        bus.rsp_ready = 1'($urandom);
      end
    end
  end

  initial begin : stimulus
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.req_tag   = '0;
    flags_clr     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.req_ready, bus.rsp_valid, fpu_start, busy, sticky}, 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1'b1);

    send(3'd0, 16'h3C00, 16'h4000, 16'h0000, 4'd5, 0, 1'b0);
    drain();
    chk("sticky_add", sticky, sticky_m);

    send(3'd2, 16'h4400, 16'h4200, 16'h0000, 4'd6, 4, 1'b1);
    drain();

    send(3'd3, 16'h3C00, 16'h0000, 16'h0000, 4'd7, 3, 1'b0);
    drain();
    chk("sticky_dz", sticky.dz, 1'b1);
    clear_sticky();

    send(3'd4, 16'h4000, 16'h0000, 16'h0000, 4'd8, TO_C + 1, 1'b0);
    drain();
    chk("sticky_nv_timeout", sticky.nv, 1'b1);

    force_hold = 5;
    send(3'd1, 16'h4000, 16'h3C00, 16'h0000, 4'd9, 1, 1'b0);
    send(3'd5, 16'h3C00, 16'h3C00, 16'h3C00, 4'd10, 2, 1'b0);
    drain();
    chk("sticky_hold", sticky, sticky_m);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        drain();
        chk("sticky_idle", sticky, sticky_m);
        if ($urandom_range(0, 1) == 1) clear_sticky();
      end
      send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
           4'($urandom), int'($urandom_range(0, 9)), 1'($urandom));
    end
    drain();
    chk("sticky_random", sticky, sticky_m);

    send(3'd2, 16'h1234, 16'h5678, 16'h9ABC, 4'hA, TO_C + 1, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait", {busy, bus.rsp_valid, fpu_start, bus.req_ready, sticky}, 64'd0);
    exp_q.delete();
    sticky_m = '0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", {bus.req_ready, busy}, 2'b10);
    repeat (20) @(negedge clk);

    send(3'd0, 16'h3C00, 16'h4000, 16'h0000, 4'd3, 2, 1'b1);
    drain();
    chk("sticky_final", sticky, sticky_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
